// File: rtl/pito_pkg.sv
`default_nettype none
// ============================================================================
// Module : pito_pkg
// Brief  : Shared types and constants for the pito program loader.
//          - loader_cmd_e   : command byte encodings that follow MAGIC
//          - loader_state_e : packet-parser FSM states
//          - LOADER_MAGIC   : packet start byte
// Rev    : 1.0  initial release
// ============================================================================
package pito_pkg;

  // Packet start byte. Only recognised while the parser is idle; inside a
  // packet the same value is ordinary payload.
  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  // Bytes per memory word on the imem/dmem write ports.
  localparam int unsigned LOADER_WORD_BYTES = 4;

  typedef enum logic [7:0] {
    CMD_IMEM = 8'h01,
    CMD_DMEM = 8'h02,
    CMD_RUN  = 8'h03
  } loader_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_LEN   = 3'd3,
    ST_DATA  = 3'd4,
    ST_WRITE = 3'd5,
    ST_CSUM  = 3'd6
  } loader_state_e;

endpackage : pito_pkg
`default_nettype wire

// File: rtl/pito_byte_packer.sv
`default_nettype none
// ============================================================================
// Module : pito_byte_packer
// Brief  : Assembles four little-endian bytes into a 32-bit word. The first
//          byte lands in bits [7:0]. word_valid_o is a combinational pulse
//          coincident with the fourth byte, and word_o already includes that
//          byte, so the caller can capture the full word on the same edge
//          that accepts the last byte.
// Ports  : clk, rst        - clock, synchronous active-high reset
//          clr_i           - restart assembly at byte 0
//          byte_i          - incoming byte
//          byte_valid_i    - byte_i is consumed this cycle
//          word_o          - assembled word (valid when word_valid_o=1)
//          word_valid_o    - fourth byte of a word is being consumed
// Rev    : 1.0  initial release
// ============================================================================
module pito_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  // Holds the three earlier bytes of the word; newest byte enters at the top
  // and earlier ones slide down toward bit 0.
  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      shift_q <= 24'd0;
      cnt_q   <= 2'd0;
    end else if (byte_valid_i) begin
      shift_q <= {byte_i, shift_q[23:8]};
      cnt_q   <= cnt_q + 2'd1;  // wraps to 0 after the fourth byte
    end
  end

endmodule : pito_byte_packer
`default_nettype wire

// File: rtl/pito_prog_loader.sv
`default_nettype none
// ============================================================================
// Module : pito_prog_loader
// Brief  : Byte-stream programming front-end for rv32_core. Parses packets
//            MAGIC CMD ADDR[4 LE] LEN[2 LE] {LEN words, 4 bytes LE} CSUM
//          or the short form MAGIC RUN, writes words into imem/dmem and
//          holds the core in reset / programming mode until RUN.
//          CSUM is the XOR of every byte after MAGIC up to the last data
//          byte.
// Ports  : clk, rst                 - clock, synchronous active-high reset
//          rx_data/rx_valid/rx_ready- byte stream in (ready/valid)
//          pito_io_program          - core in programming mode
//          core_rst                 - reset request to core
//          pito_io_imem_w_en/_addr  - imem write strobe / word address
//          pito_io_dmem_w_en/_addr  - dmem write strobe / word address
//          pito_io_mem_wdata        - write data shared by both memories
//          busy                     - packet in progress
//          done                     - one-cycle pulse after a good packet/RUN
//          err                      - sticky error, cleared by next MAGIC
// Rev    : 1.0  initial release
// ============================================================================
module pito_prog_loader
  import pito_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [7:0]  MAGIC  = LOADER_MAGIC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              pito_io_program,
  output logic              core_rst,
  output logic              pito_io_imem_w_en,
  output logic              pito_io_dmem_w_en,
  output logic [ADDR_W-1:0] pito_io_imem_addr,
  output logic [ADDR_W-1:0] pito_io_dmem_addr,
  output logic [DATA_W-1:0] pito_io_mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  loader_state_e     state_q,     state_d;
  logic              sel_dmem_q,  sel_dmem_d;   // target memory of this packet
  logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;   // next word address to write
  logic [15:0]       count_q,     count_d;      // words still to write
  logic              len_hi_q,    len_hi_d;     // second LEN byte expected
  logic [7:0]        csum_q,      csum_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;
  logic              core_rst_q,  core_rst_d;
  logic              program_q,   program_d;

  logic              w_accept;
  logic              w_pk_clr;
  logic              w_pk_valid;
  logic [31:0]       w_pk_word;
  logic              w_pk_word_valid;

  assign w_accept = rx_valid && rx_ready;

  // Shared between the ADDR field and each DATA word; both are whole
  // multiples of four bytes, so the packer is back at byte 0 between them.
  pito_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (w_pk_clr),
    .byte_i       (rx_data),
    .byte_valid_i (w_pk_valid),
    .word_o       (w_pk_word),
    .word_valid_o (w_pk_word_valid)
  );

  always_comb begin
    state_d     = state_q;
    sel_dmem_d  = sel_dmem_q;
    cur_addr_d  = cur_addr_q;
    count_d     = count_q;
    len_hi_d    = len_hi_q;
    csum_d      = csum_q;
    imem_addr_d = imem_addr_q;
    dmem_addr_d = dmem_addr_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    err_d       = err_q;
    core_rst_d  = core_rst_q;
    program_d   = program_q;
    w_pk_clr    = 1'b0;
    w_pk_valid  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Anything other than MAGIC is line noise and silently dropped.
        if (w_accept && (rx_data == MAGIC)) begin
          state_d  = ST_CMD;
          err_d    = 1'b0;
          csum_d   = 8'd0;
          w_pk_clr = 1'b1;
        end
      end

      ST_CMD: begin
        if (w_accept) begin
          csum_d = csum_q ^ rx_data;
          case (rx_data)
            CMD_IMEM, CMD_DMEM: begin
              sel_dmem_d = (rx_data == CMD_DMEM);
              program_d  = 1'b1;
              core_rst_d = 1'b1;
              state_d    = ST_ADDR;
            end
            CMD_RUN: begin
              program_d  = 1'b0;
              core_rst_d = 1'b0;
              done_d     = 1'b1;
              state_d    = ST_IDLE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
      end

      ST_ADDR: begin
        if (w_accept) begin
          csum_d     = csum_q ^ rx_data;
          w_pk_valid = 1'b1;
          if (w_pk_word_valid) begin
            cur_addr_d = ADDR_W'(w_pk_word);
            len_hi_d   = 1'b0;
            state_d    = ST_LEN;
          end
        end
      end

      ST_LEN: begin
        if (w_accept) begin
          csum_d = csum_q ^ rx_data;
          if (!len_hi_q) begin
            count_d[7:0] = rx_data;
            len_hi_d     = 1'b1;
          end else begin
            count_d[15:8] = rx_data;
            state_d = ({rx_data, count_q[7:0]} == 16'd0) ? ST_CSUM : ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (w_accept) begin
          csum_d     = csum_q ^ rx_data;
          w_pk_valid = 1'b1;
          // Stage address/data now so they are stable for the whole WRITE
          // cycle and the unselected memory's address is left untouched.
          if (w_pk_word_valid) begin
            wdata_d = DATA_W'(w_pk_word);
            if (sel_dmem_q) begin
              dmem_addr_d = cur_addr_q;
            end else begin
              imem_addr_d = cur_addr_q;
            end
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        cur_addr_d = cur_addr_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
        count_d    = count_q - 16'd1;
        state_d    = (count_q == 16'd1) ? ST_CSUM : ST_DATA;
      end

      ST_CSUM: begin
        if (w_accept) begin
          state_d = ST_IDLE;
          // Words already written stay written on a mismatch.
          if (rx_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_dmem_q  <= 1'b0;
      cur_addr_q  <= '0;
      count_q     <= 16'd0;
      len_hi_q    <= 1'b0;
      csum_q      <= 8'd0;
      imem_addr_q <= '0;
      dmem_addr_q <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      core_rst_q  <= 1'b1;
      program_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      sel_dmem_q  <= sel_dmem_d;
      cur_addr_q  <= cur_addr_d;
      count_q     <= count_d;
      len_hi_q    <= len_hi_d;
      csum_q      <= csum_d;
      imem_addr_q <= imem_addr_d;
      dmem_addr_q <= dmem_addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      core_rst_q  <= core_rst_d;
      program_q   <= program_d;
    end
  end

  // WRITE is the only state that does not take a byte; it is the single
  // cycle in which the selected memory sees its strobe.
  assign rx_ready          = (state_q != ST_WRITE);
  assign busy              = (state_q != ST_IDLE);
  assign pito_io_imem_w_en = (state_q == ST_WRITE) && !sel_dmem_q;
  assign pito_io_dmem_w_en = (state_q == ST_WRITE) &&  sel_dmem_q;
  assign pito_io_imem_addr = imem_addr_q;
  assign pito_io_dmem_addr = dmem_addr_q;
  assign pito_io_mem_wdata = wdata_q;
  assign done              = done_q;
  assign err               = err_q;
  assign core_rst          = core_rst_q;
  assign pito_io_program   = program_q;

endmodule : pito_prog_loader
`default_nettype wire

// File: tb/tb_pito_prog_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_pito_prog_loader
// Brief  : Directed self-checking bench for pito_prog_loader. Drives packets
//          with hand-computed checksums and expected write addresses/data,
//          with random idle gaps between bytes.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pito_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        pito_io_program;
  logic        core_rst;
  logic        pito_io_imem_w_en;
  logic        pito_io_dmem_w_en;
  logic [31:0] pito_io_imem_addr;
  logic [31:0] pito_io_dmem_addr;
  logic [31:0] pito_io_mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_imem_addr = 32'd0;
  logic [31:0] exp_dmem_addr = 32'd0;

  always #5 clk = ~clk;

  pito_prog_loader dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .pito_io_program   (pito_io_program),
    .core_rst          (core_rst),
    .pito_io_imem_w_en (pito_io_imem_w_en),
    .pito_io_dmem_w_en (pito_io_dmem_w_en),
    .pito_io_imem_addr (pito_io_imem_addr),
    .pito_io_dmem_addr (pito_io_dmem_addr),
    .pito_io_mem_wdata (pito_io_mem_wdata),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe / done observer on the inactive edge.
  always @(negedge clk) begin
    if (pito_io_imem_w_en === 1'b1 || pito_io_dmem_w_en === 1'b1) begin
      wr_cnt++;
      chk("wr_rx_ready_low", {63'd0, rx_ready}, 64'd0);
      chk("wr_onehot", {63'd0, pito_io_imem_w_en & pito_io_dmem_w_en}, 64'd0);
    end
    if (done === 1'b1) done_cnt++;
  end

  // Called and returns just after a negedge. Random idle gap first.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    int gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      ok = rx_ready;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  // Sends a full load packet; checks every write strobe in its WRITE cycle.
  task automatic load(input logic [7:0] cmd, input logic [31:0] addr, input logic [15:0] len,
                      input logic [31:0] w0, input logic [31:0] a0,
                      input logic [31:0] w1, input logic [31:0] a1,
                      input logic [7:0] cs);
    logic [31:0] w;
    logic [31:0] a;
    send_byte(8'hA5);
    send_byte(cmd);
    send_word(addr);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int i = 0; i < int'(len); i++) begin
      w = (i == 0) ? w0 : w1;
      a = (i == 0) ? a0 : a1;
      send_word(w);
      chk("imem_w_en", {63'd0, pito_io_imem_w_en}, {63'd0, cmd == 8'h01});
      chk("dmem_w_en", {63'd0, pito_io_dmem_w_en}, {63'd0, cmd == 8'h02});
      if (cmd == 8'h01) exp_imem_addr = a;
      else              exp_dmem_addr = a;
      chk("imem_addr", {32'd0, pito_io_imem_addr}, {32'd0, exp_imem_addr});
      chk("dmem_addr", {32'd0, pito_io_dmem_addr}, {32'd0, exp_dmem_addr});
      chk("wdata", {32'd0, pito_io_mem_wdata}, {32'd0, w});
      @(negedge clk);
      chk("w_en_one_cycle", {63'd0, pito_io_imem_w_en | pito_io_dmem_w_en}, 64'd0);
    end
    send_byte(cs);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_core_rst"}, {63'd0, core_rst}, 64'd1);
    chk({tag, "_program"}, {63'd0, pito_io_program}, 64'd1);
    chk({tag, "_imem_w_en"}, {63'd0, pito_io_imem_w_en}, 64'd0);
    chk({tag, "_dmem_w_en"}, {63'd0, pito_io_dmem_w_en}, 64'd0);
    chk({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd1);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_imem_addr"}, {32'd0, pito_io_imem_addr}, 64'd0);
    chk({tag, "_dmem_addr"}, {32'd0, pito_io_dmem_addr}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, pito_io_mem_wdata}, 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_values("reset");

    // Line noise before the first packet is dropped without error.
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("garbage_busy", {63'd0, busy}, 64'd0);
    chk("garbage_err", {63'd0, err}, 64'd0);

    // imem load, two words at 0x10, CSUM 0x22.
    load(8'h01, 32'h10, 16'd2, 32'h00000013, 32'h10, 32'hDEADBEEF, 32'h11, 8'h22);
    chk("imem_done", {63'd0, done}, 64'd1);
    chk("imem_err", {63'd0, err}, 64'd0);
    chk("imem_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("imem_done_pulse", {63'd0, done}, 64'd0);

    // dmem load with bad checksum (good one is 0x21).
    load(8'h02, 32'h10, 16'd2, 32'h00000013, 32'h10, 32'hDEADBEEF, 32'h11, 8'hDE);
    chk("bad_csum_err", {63'd0, err}, 64'd1);
    chk("bad_csum_no_done", {63'd0, done}, 64'd0);
    send_byte(8'hA5);
    chk("magic_clears_err", {63'd0, err}, 64'd0);
    chk("magic_busy", {63'd0, busy}, 64'd1);
    send_byte(8'h07);
    chk("bad_cmd_err", {63'd0, err}, 64'd1);
    chk("bad_cmd_idle", {63'd0, busy}, 64'd0);

    // RUN releases the core.
    send_byte(8'hA5);
    send_byte(8'h03);
    chk("run_core_rst", {63'd0, core_rst}, 64'd0);
    chk("run_program", {63'd0, pito_io_program}, 64'd0);
    chk("run_done", {63'd0, done}, 64'd1);
    chk("run_err", {63'd0, err}, 64'd0);
    chk("run_busy", {63'd0, busy}, 64'd0);

    // Address wrap: 0xFFFFFFFF then 0x00000000; CSUM 0x03.
    load(8'h01, 32'hFFFFFFFF, 16'd2, 32'h11111111, 32'hFFFFFFFF, 32'h22222222, 32'h00000000, 8'h03);
    chk("wrap_done", {63'd0, done}, 64'd1);
    chk("wrap_core_rst", {63'd0, core_rst}, 64'd1);
    chk("wrap_program", {63'd0, pito_io_program}, 64'd1);

    // Zero-length dmem packet: no writes, checksum 0x42 checked.
    load(8'h02, 32'h40, 16'd0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h42);
    chk("len0_done", {63'd0, done}, 64'd1);
    chk("len0_err", {63'd0, err}, 64'd0);
    chk("len0_dmem_addr_hold", {32'd0, pito_io_dmem_addr}, {32'd0, exp_dmem_addr});

    // RUN again, then a load command re-asserts programming mode.
    send_byte(8'hA5);
    send_byte(8'h03);
    chk("run2_core_rst", {63'd0, core_rst}, 64'd0);
    send_byte(8'hA5);
    send_byte(8'h01);
    chk("reload_core_rst", {63'd0, core_rst}, 64'd1);
    chk("reload_program", {63'd0, pito_io_program}, 64'd1);

    // Abort with reset in the middle of the first data word.
    send_word(32'h00000020);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hEF);
    send_byte(8'hBE);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_values("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_idle_busy", {63'd0, busy}, 64'd0);

    chk("total_writes", 64'(wr_cnt), 64'd6);
    chk("total_done", 64'(done_cnt), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pito_prog_loader
`default_nettype wire
